cpu_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the PC write, register-file write, ALU operand/writeback muxes and data-memory strobes of the cpe_cpu datapath from the opcode of the latched instruction. It sits beside `pc`, `registers`, `alu` and `cond_branch_control` inside cpe_cpu and replaces the tied-off `pc_w_i`/`reg_wr_flag_w_i` wiring.

---
 rtl/cpu_seq_ctrl_if.sv | 36 +++
 rtl/cpu_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_if.sv
// rtl/cpu_seq_ctrl_if.sv - handshake and control bundle between the sequencer and the cpe_cpu datapath
interface cpu_seq_ctrl_if;
  logic [31:0] instr_w_i;
  logic        mem_ack_w_i_h;
  logic        cond_branch_w_i_h;
  logic        fetch_req_w_o_h;
  logic        ir_wr_w_o_h;
  logic        pc_wr_w_o_h;
  logic [1:0]  pc_sel_w_o;
  logic        alu_a_sel_w_o;
  logic        alu_b_sel_w_o;
  logic [1:0]  wb_sel_w_o;
  logic        reg_wr_flag_w_o;
  logic        mem_rd_w_o_h;
  logic        mem_wr_w_o_h;
  logic [1:0]  mem_rd_byte_sel_w_o;
  logic [1:0]  mem_wr_byte_sel_w_o;
  logic        trap_w_o_h;
  logic [2:0]  state_w_o;

  modport master (
    input  instr_w_i, mem_ack_w_i_h, cond_branch_w_i_h,
    output fetch_req_w_o_h, ir_wr_w_o_h, pc_wr_w_o_h, pc_sel_w_o,
           alu_a_sel_w_o, alu_b_sel_w_o, wb_sel_w_o, reg_wr_flag_w_o,
           mem_rd_w_o_h, mem_wr_w_o_h, mem_rd_byte_sel_w_o, mem_wr_byte_sel_w_o,
           trap_w_o_h, state_w_o
  );

  modport slave (
    output instr_w_i, mem_ack_w_i_h, cond_branch_w_i_h,
    input  fetch_req_w_o_h, ir_wr_w_o_h, pc_wr_w_o_h, pc_sel_w_o,
           alu_a_sel_w_o, alu_b_sel_w_o, wb_sel_w_o, reg_wr_flag_w_o,
           mem_rd_w_o_h, mem_wr_w_o_h, mem_rd_byte_sel_w_o, mem_wr_byte_sel_w_o,
           trap_w_o_h, state_w_o
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb)
module cpu_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk_w_i,
  input  logic           res_w_i_h,
  cpu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
  } cls_e;

  localparam logic [7:0] TmoLimit = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic [7:0] tmo_q, tmo_d;

  logic       ack;
  logic       fetch_req, ir_wr, pc_wr, reg_wr, mem_rd, mem_wr;
  logic       alu_a, alu_b;
  logic [1:0] pc_sel, wb_sel, rd_bs, wr_bs;
  logic       rd_is_x0;
  logic       unused_instr_bits;

  assign ack               = bus.mem_ack_w_i_h;
  assign rd_is_x0          = (bus.instr_w_i[11:7] == 5'd0);
  assign unused_instr_bits = ^bus.instr_w_i[31:14];

  // Non-11 low bits never match a listed opcode, so they fall into CL_ILLEGAL.
  always_comb begin
    dec_cls = CL_ILLEGAL;
    case (bus.instr_w_i[6:0])
      7'h33:   dec_cls = CL_OP;
      7'h13:   dec_cls = CL_OPIMM;
      7'h03:   dec_cls = CL_LOAD;
      7'h23:   dec_cls = CL_STORE;
      7'h63:   dec_cls = CL_BRANCH;
      7'h6F:   dec_cls = CL_JAL;
      7'h67:   dec_cls = CL_JALR;
      7'h37:   dec_cls = CL_LUI;
      7'h17:   dec_cls = CL_AUIPC;
      7'h0F:   dec_cls = CL_FENCE;
      7'h73:   dec_cls = CL_SYSTEM;
      default: dec_cls = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    tmo_d     = tmo_q;
    fetch_req = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_sel    = 2'd0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    wb_sel    = 2'd0;
    reg_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    rd_bs     = 2'd0;
    wr_bs     = 2'd0;

    // ALU muxes stay put past EXEC so the combinational ALU result remains valid for MEM and WB.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_a = (cls_q == CL_AUIPC);
      alu_b = (cls_q == CL_AUIPC) || (cls_q == CL_OPIMM) || (cls_q == CL_LOAD) ||
              (cls_q == CL_STORE) || (cls_q == CL_JALR);
    end

    case (state_q)
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (ack) begin
          ir_wr   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_q == TmoLimit) begin
          state_d = ST_TRAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      ST_DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end

      ST_EXEC: begin
        case (cls_q)
          CL_LOAD, CL_STORE: begin
            state_d = ST_MEM;
            tmo_d   = 8'd0;
          end
          CL_BRANCH: begin
            pc_wr   = 1'b1;
            pc_sel  = bus.cond_branch_w_i_h ? 2'd1 : 2'd0;
            state_d = ST_FETCH;
            tmo_d   = 8'd0;
          end
          CL_FENCE: begin
            pc_wr   = 1'b1;
            state_d = ST_FETCH;
            tmo_d   = 8'd0;
          end
          CL_SYSTEM, CL_ILLEGAL: state_d = ST_TRAP;
          default:               state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem_rd = (cls_q == CL_LOAD);
        mem_wr = (cls_q == CL_STORE);
        rd_bs  = mem_rd ? bus.instr_w_i[13:12] : 2'd0;
        wr_bs  = mem_wr ? bus.instr_w_i[13:12] : 2'd0;
        if (ack) begin
          if (mem_rd) begin
            state_d = ST_WB;
          end else begin
            pc_wr   = 1'b1;
            state_d = ST_FETCH;
            tmo_d   = 8'd0;
          end
        end else if (tmo_q == TmoLimit) begin
          state_d = ST_TRAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      ST_WB: begin
        reg_wr = !rd_is_x0;
        pc_wr  = 1'b1;
        case (cls_q)
          CL_LOAD: wb_sel = 2'd1;
          CL_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
          CL_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
          CL_LUI:  wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
        state_d = ST_FETCH;
        tmo_d   = 8'd0;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      state_q <= ST_FETCH;
      cls_q   <= CL_ILLEGAL;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tmo_q   <= tmo_d;
    end
  end

  // Strobes are masked during reset so an aborted instruction never writes PC, registers or memory.
  assign bus.fetch_req_w_o_h     = fetch_req & ~res_w_i_h;
  assign bus.ir_wr_w_o_h         = ir_wr & ~res_w_i_h;
  assign bus.pc_wr_w_o_h         = pc_wr & ~res_w_i_h;
  assign bus.pc_sel_w_o          = pc_sel & {2{~res_w_i_h}};
  assign bus.alu_a_sel_w_o       = alu_a & ~res_w_i_h;
  assign bus.alu_b_sel_w_o       = alu_b & ~res_w_i_h;
  assign bus.wb_sel_w_o          = wb_sel & {2{~res_w_i_h}};
  assign bus.reg_wr_flag_w_o     = reg_wr & ~res_w_i_h;
  assign bus.mem_rd_w_o_h        = mem_rd & ~res_w_i_h;
  assign bus.mem_wr_w_o_h        = mem_wr & ~res_w_i_h;
  assign bus.mem_rd_byte_sel_w_o = rd_bs & {2{~res_w_i_h}};
  assign bus.mem_wr_byte_sel_w_o = wr_bs & {2{~res_w_i_h}};
  assign bus.trap_w_o_h          = (state_q == ST_TRAP);
  assign bus.state_w_o           = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - scoreboard bench for cpu_seq_ctrl with a per-cycle behavioural model
module tb_cpu_seq_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [2:0] st;
    logic       fetch_req;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       alu_a;
    logic       alu_b;
    logic [1:0] wb_sel;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] rd_bs;
    logic [1:0] wr_bs;
    logic       trap;
  } obs_t;

  typedef struct {
    obs_t v;
    bit   alu_chk;
    int   tag;
  } exp_t;

  typedef struct {
    bit          res;
    bit          ack;
    bit          cond;
    logic [31:0] ins;
  } drv_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  cpu_seq_ctrl_if bus();

  cpu_seq_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_w_i   (clk),
    .res_w_i_h (res),
    .bus       (bus)
  );

  exp_t        exq[$];
  drv_t        plan[$];
  int          checks   = 0;
  int          failures = 0;
  int          cur_tag  = 0;
  bit          cur_cond = 1'b0;
  logic [31:0] cur_ins  = 32'h0;
  logic [2:0]  last_st  = 3'd0;
  int          cyc      = 0;
  logic [6:0]  ops[11]  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                            7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

  task automatic emit(input obs_t v, input bit ac, input bit r, input bit a);
    exp_t e;
    drv_t d;
    e.v = v; e.alu_chk = ac; e.tag = cur_tag;
    d.res = r; d.ack = a; d.cond = cur_cond; d.ins = cur_ins;
    exq.push_back(e);
    plan.push_back(d);
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction; waits beyond TIMEOUT end in TRAP.
  task automatic model_instr(input logic [31:0] ins, input int fw, input int mw, input bit cond);
    obs_t       o;
    logic [6:0] op;
    bit         ld, sto, br, jal, jalr, lui, auipc, fence, sys, opimm, legal;
    op = ins[6:0];
    cur_ins = ins;
    cur_cond = cond;
    ld = (op == 7'h03); sto = (op == 7'h23); br = (op == 7'h63);
    jal = (op == 7'h6F); jalr = (op == 7'h67); lui = (op == 7'h37);
    auipc = (op == 7'h17); fence = (op == 7'h0F); sys = (op == 7'h73);
    opimm = (op == 7'h13);
    legal = (ins[1:0] == 2'b11) &&
            (ld || sto || br || jal || jalr || lui || auipc || fence || sys || opimm || op == 7'h33);

    for (int i = 0; i <= fw && i <= TIMEOUT; i++) begin
      o = '0; o.st = 3'd0; o.fetch_req = 1'b1; o.ir_wr = (i == fw);
      emit(o, 1'b0, 1'b0, i == fw);
    end
    if (fw > TIMEOUT) begin last_st = 3'd7; return; end

    o = '0; o.st = 3'd1;
    emit(o, 1'b0, 1'b0, rbit());
    if (!legal) begin last_st = 3'd7; return; end

    o = '0; o.st = 3'd2;
    o.alu_a = auipc;
    o.alu_b = auipc || opimm || ld || sto || jalr;
    if (br)    begin o.pc_wr = 1'b1; o.pc_sel = cond ? 2'd1 : 2'd0; end
    if (fence) o.pc_wr = 1'b1;
    emit(o, 1'b1, 1'b0, rbit());
    if (br || fence) begin last_st = 3'd0; return; end
    if (sys)         begin last_st = 3'd7; return; end

    if (ld || sto) begin
      for (int j = 0; j <= mw && j <= TIMEOUT; j++) begin
        o = '0; o.st = 3'd3;
        o.mem_rd = ld; o.mem_wr = sto;
        o.rd_bs = ld ? ins[13:12] : 2'd0;
        o.wr_bs = sto ? ins[13:12] : 2'd0;
        o.pc_wr = sto && (j == mw);
        emit(o, 1'b0, 1'b0, j == mw);
      end
      if (mw > TIMEOUT) begin last_st = 3'd7; return; end
      if (sto)          begin last_st = 3'd0; return; end
    end

    o = '0; o.st = 3'd4;
    o.reg_wr = (ins[11:7] != 5'd0);
    o.wb_sel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
    o.pc_wr  = 1'b1;
    o.pc_sel = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    emit(o, 1'b0, 1'b0, rbit());
    last_st = 3'd0;
  endtask

  task automatic model_trap(input int n);
    obs_t o;
    for (int k = 0; k < n; k++) begin
      o = '0; o.st = 3'd7; o.trap = 1'b1;
      emit(o, 1'b0, 1'b0, rbit());
    end
  endtask

  // The reset cycle itself still shows the old state; everything is idle FETCH afterwards.
  task automatic model_reset(input int n, input bit ack0);
    obs_t o;
    for (int k = 0; k < n; k++) begin
      o = '0;
      o.st = (k == 0) ? last_st : 3'd0;
      o.trap = (k == 0) && (last_st == 3'd7);
      emit(o, 1'b0, 1'b1, (k == 0) ? ack0 : rbit());
    end
    last_st = 3'd0;
  endtask

  task automatic run_plan();
    drv_t p;
    while (plan.size() > 0) begin
      p = plan.pop_front();
      res = p.res;
      bus.mem_ack_w_i_h = p.ack;
      bus.cond_branch_w_i_h = p.cond;
      bus.instr_w_i = p.ins;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input int tag, input logic [31:0] ins, input int fw, input int mw,
                          input bit cond, input int hold);
    cur_tag = tag;
    model_instr(ins, fw, mw, cond);
    if (last_st == 3'd7) begin
      model_trap(hold);
      model_reset(1 + $urandom_range(0, 1), rbit());
    end
    run_plan();
  endtask

  function automatic obs_t sample_obs();
    obs_t o;
    o.st = bus.state_w_o;           o.fetch_req = bus.fetch_req_w_o_h;
    o.ir_wr = bus.ir_wr_w_o_h;      o.pc_wr = bus.pc_wr_w_o_h;
    o.pc_sel = bus.pc_sel_w_o;      o.alu_a = bus.alu_a_sel_w_o;
    o.alu_b = bus.alu_b_sel_w_o;    o.wb_sel = bus.wb_sel_w_o;
    o.reg_wr = bus.reg_wr_flag_w_o; o.mem_rd = bus.mem_rd_w_o_h;
    o.mem_wr = bus.mem_wr_w_o_h;    o.rd_bs = bus.mem_rd_byte_sel_w_o;
    o.wr_bs = bus.mem_wr_byte_sel_w_o; o.trap = bus.trap_w_o_h;
    return o;
  endfunction

  obs_t act;
  exp_t cur;
  logic prev_pc_wr = 1'b0, prev_ir_wr = 1'b0, prev_reg_wr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    act = sample_obs();
    if (exq.size() > 0) begin
      cur = exq.pop_front();
      if (!cur.alu_chk) begin
        act.alu_a = cur.v.alu_a;
        act.alu_b = cur.v.alu_b;
      end
      checks++;
      if (act !== cur.v) begin
        failures++;
        $display("FAIL trace tag=%0d cyc=%0d state act=%0d exp=%0d vec act=%05h exp=%05h",
                 cur.tag, cyc, act.st, cur.v.st, act, cur.v);
      end
    end
    checks++;
    if (bus.mem_rd_w_o_h && bus.mem_wr_w_o_h) begin
      failures++;
      $display("FAIL rd_wr_overlap cyc=%0d act=both_high exp=exclusive", cyc);
    end
    checks++;
    if ((prev_pc_wr && bus.pc_wr_w_o_h) || (prev_ir_wr && bus.ir_wr_w_o_h) ||
        (prev_reg_wr && bus.reg_wr_flag_w_o)) begin
      failures++;
      $display("FAIL strobe_pulse cyc=%0d act=two_cycles exp=single", cyc);
    end
    checks++;
    if (bus.reg_wr_flag_w_o && !bus.pc_wr_w_o_h) begin
      failures++;
      $display("FAIL regwr_with_pcwr cyc=%0d act=pc_wr0 exp=pc_wr1", cyc);
    end
    prev_pc_wr  = bus.pc_wr_w_o_h;
    prev_ir_wr  = bus.ir_wr_w_o_h;
    prev_reg_wr = bus.reg_wr_flag_w_o;
  end

  initial begin
    int          n0;
    logic [31:0] r, ins;
    int          sel;
    res = 1'b1;
    bus.mem_ack_w_i_h = 1'b0;
    bus.cond_branch_w_i_h = 1'b0;
    bus.instr_w_i = 32'h0;
    @(posedge clk);
    #1;

    cur_tag = 0; last_st = 3'd0;
    model_reset(2, 1'b0);
    run_plan();

    do_instr(1,  32'h002081B3, 0, 0, 1'b0, 2);
    do_instr(2,  32'h0080A283, 0, 3, 1'b0, 2);
    do_instr(3,  32'h00208463, 0, 0, 1'b1, 2);
    do_instr(4,  32'h00208463, 1, 0, 1'b0, 2);
    do_instr(5,  32'h00008067, 0, 0, 1'b0, 2);
    do_instr(6,  32'h0000007F, 0, 0, 1'b0, 20);
    do_instr(7,  32'h002081B3, 16, 0, 1'b0, 3);
    do_instr(8,  32'h002081B3, 15, 0, 1'b0, 2);
    do_instr(9,  32'h0010A023, 0, 16, 1'b0, 3);
    do_instr(10, 32'h0080A283, 2, 15, 1'b0, 2);
    do_instr(11, 32'h00000073, 0, 0, 1'b0, 2);
    do_instr(12, 32'h00000030, 0, 0, 1'b0, 2);
    do_instr(13, 32'h0000500F, 0, 0, 1'b1, 2);
    do_instr(14, 32'h123450B7, 0, 0, 1'b0, 2);
    do_instr(15, 32'h0040006F, 1, 0, 1'b0, 2);

    // Store interrupted by reset while the write request is up (ack also offered that cycle).
    cur_tag = 16;
    n0 = exq.size();
    model_instr(32'h0010A023, 0, 8, 1'b0);
    while (exq.size() > n0 + 5) begin
      void'(exq.pop_back());
      void'(plan.pop_back());
    end
    last_st = 3'd3;
    model_reset(2, 1'b1);
    run_plan();

    for (int t = 0; t < 150; t++) begin
      r = $urandom();
      sel = $urandom_range(0, 11);
      if (sel == 11) ins = r;
      else           ins = {r[31:7], ops[sel]};
      do_instr(100 + t, ins, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), $urandom_range(1, 3));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain act=%0d exp=0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
